cls_seq_32bit: RTL and testbench

Nibble-serial add/subtract sequencer built around one `cls_4bit` carry look-ahead slice. It accepts a WIDTH-bit operand pair and an operation code, and drives the shared 4-bit slice one nibble per cycle, LSB first. The carry is chained between cycles through a register, and the full result is assembled in an output register. It sits between a requesting control unit and the `cls_4bit` slice, trading latency for area versus a fully parallel 32-bit CLS.

---
 rtl/cls_seq_32bit_if.sv | 26 ++
 rtl/cls_seq_32bit.sv | 148 ++++++++++++++
 tb/tb_cls_seq_32bit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cls_seq_32bit_if.sv
// Request/result bundle between a control unit and the nibble-serial add/subtract sequencer.
// Handshake: start is a request taken only while the sequencer is idle (busy=0, done=0);
// done is a one-cycle valid with no ready, and result/carry_out/overflow stay valid until the next accepted start.
interface cls_seq_32bit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, op, a, b,
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, carry_out, overflow
   );
endinterface

// File: rtl/cls_seq_32bit.sv
// Nibble-serial add/subtract sequencer: one 4-bit carry look-ahead slice reused LSB-first across WIDTH/4 cycles.
// Optional macro CLS_SEQ_OVF_EN compiles in the signed-overflow flag; without it overflow is tied to 0.
module cls_seq_32bit #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   cls_seq_32bit_if.slave  bus,
   output logic [1:0]      o_dbg_state
);

   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_op;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_carry_out;
   logic             r_ovf;

   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_feed;
   logic [3:0]       w_bi;
   logic [3:0]       w_g;
   logic [3:0]       w_p;
   logic [4:0]       w_c;
   logic [3:0]       w_sum;
   logic             w_cout;
   logic             w_last;
   logic [CW+1:0]    w_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   assign w_last = (r_cnt == LAST);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Slice always computes a + ~b_in + cin: subtract feeds b as-is, add pre-inverts it.
   assign w_base   = {r_cnt, 2'b00};
   assign w_a_nib  = r_a[w_base +: 4];
   assign w_b_feed = r_op ? ~r_b[w_base +: 4] : r_b[w_base +: 4];
   assign w_bi     = ~w_b_feed;
   assign w_g      = w_a_nib & w_bi;
   assign w_p      = w_a_nib ^ w_bi;

   always_comb begin
      w_c    = '0;
      w_c[0] = r_carry;
      w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   end

   assign w_sum  = w_p ^ w_c[3:0];
   assign w_cout = w_c[4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= 1'b0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a         <= bus.a;
                  r_b         <= bus.b;
                  r_op        <= bus.op;
                  r_cnt       <= '0;
                  r_carry     <= ~bus.op;
                  r_result    <= '0;
                  r_carry_out <= 1'b0;
               end
            end
            S_RUN: begin
               r_result[w_base +: 4] <= w_sum;
               r_carry               <= w_cout;
               // Final carry is published on the last nibble so it is already valid during DONE.
               if (w_last) r_carry_out <= w_cout;
               else        r_cnt       <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef CLS_SEQ_OVF_EN
   logic w_a_msb;
   logic w_b_msb;
   logic w_ovf;

   assign w_a_msb = r_a[WIDTH-1];
   assign w_b_msb = r_b[WIDTH-1];
   assign w_ovf   = r_op ? ((w_a_msb == w_b_msb) & (w_sum[3] != w_a_msb))
                         : ((w_a_msb != w_b_msb) & (w_sum[3] != w_a_msb));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_RUN && w_last) begin
         r_ovf <= w_ovf;
      end
   end
`else
   assign r_ovf = 1'b0;
`endif

   assign bus.busy      = (r_state == S_RUN);
   assign bus.done      = (r_state == S_DONE);
   assign bus.result    = r_result;
   assign bus.carry_out = r_carry_out;
   assign bus.overflow  = r_ovf;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cls_seq_32bit.sv
// Self-checking bench for cls_seq_32bit: reference timing model plus scoreboard of expected {overflow, carry, result}.
module tb_cls_seq_32bit;

   localparam int W = 32;
   localparam int N = W / 4;

   logic clk;
   logic rst_n;
   logic [1:0] dbg_state;

   cls_seq_32bit_if #(.WIDTH(W)) bus ();

   cls_seq_32bit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W+1:0] exp_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           m_cnt = 0;
   int           n_acc = 0;
   int           n_done = 0;
   logic [W+1:0] m_pend = '0;
   logic [W+1:0] m_hold = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Independent arithmetic reference: {overflow, carry_out, result}.
   function automatic logic [W+1:0] ref_model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]   s;
      logic [W:0]   ss;
      logic         ov;
      if (op) begin
         s  = {1'b0, a} + {1'b0, b};
         ss = {a[W-1], a} + {b[W-1], b};
      end else begin
         s[W-1:0] = a - b;
         s[W]     = (a >= b);
         ss       = {a[W-1], a} - {b[W-1], b};
      end
`ifdef CLS_SEQ_OVF_EN
      ov = ss[W] ^ ss[W-1];
`else
      ov = 1'b0;
`endif
      return {ov, s[W], s[W-1:0]};
   endfunction

   // Acceptance/timing model: m_cnt = N+1 in first RUN cycle, 1 in DONE, 0 when idle.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_cnt  = 0;
         m_hold = '0;
         m_pend = '0;
         exp_q.delete();
      end else begin
         if (m_cnt == 1) m_hold = m_pend;
         if (m_cnt != 0) begin
            m_cnt = m_cnt - 1;
         end else if (bus.start) begin
            m_pend = ref_model(bus.op, bus.a, bus.b);
            exp_q.push_back(m_pend);
            m_cnt = N + 1;
            n_acc++;
         end
      end
   end

   // Output monitor, sampled on the falling edge.
   int busy_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         check("busy", bus.busy, (m_cnt >= 2 && m_cnt <= N + 1));
         check("done", bus.done, (m_cnt == 1));
         if (bus.busy) busy_cnt++;
         if (m_cnt == N + 1) begin
            check("clr_result", bus.result, 0);
            check("clr_carry", bus.carry_out, 0);
            check("clr_ovf", bus.overflow, 0);
         end
         if (m_cnt == 0) begin
            check("hold_result", bus.result, m_hold[W-1:0]);
            check("hold_carry", bus.carry_out, m_hold[W]);
            check("hold_ovf", bus.overflow, m_hold[W+1]);
         end
         if (bus.done) begin
            logic [W+1:0] e;
            n_done++;
            check("busy_len", busy_cnt, N);
            busy_cnt = 0;
            check("sb_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_result", bus.result, e[W-1:0]);
               check("sb_carry", bus.carry_out, e[W]);
               check("sb_ovf", bus.overflow, e[W+1]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done();
      int g = 0;
      while (!bus.done && g < 40) begin
         @(negedge clk);
         g++;
      end
      check("done_seen", bus.done, 1);
      @(negedge clk);
   endtask

   task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
   endtask

   task automatic wait_idle();
      int g = 0;
      while (m_cnt != 0 && g < 60) begin
         @(negedge clk);
         g++;
      end
      check("idle_reached", (m_cnt == 0), 1);
      @(negedge clk);
   endtask

   logic exp_ovf_flag;

   // ---------------- main sequence ----------------
   initial begin
      int acc0;
      int done0;
`ifdef CLS_SEQ_OVF_EN
      exp_ovf_flag = 1'b1;
`else
      exp_ovf_flag = 1'b0;
`endif
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_result", bus.result, 0);
      check("rst_carry", bus.carry_out, 0);
      check("rst_ovf", bus.overflow, 0);
      check("rst_state", dbg_state, 0);
      #2 rst_n = 1'b1;

      run_op(1'b0, 32'h0000_0010, 32'h0000_0001);
      check("sub_10_1", bus.result, 32'h0000_000F);
      check("sub_10_1_c", bus.carry_out, 1);

      run_op(1'b0, 32'h0000_0000, 32'h0000_0001);
      check("sub_0_1", bus.result, 32'hFFFF_FFFF);
      check("sub_0_1_c", bus.carry_out, 0);

      run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
      check("add_wrap", bus.result, 32'h0000_0000);
      check("add_wrap_c", bus.carry_out, 1);

      run_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
      check("add_ovf", bus.result, 32'h8000_0000);
      check("add_ovf_f", bus.overflow, exp_ovf_flag);

      run_op(1'b0, 32'h8000_0000, 32'h0000_0001);
      check("sub_ovf", bus.result, 32'h7FFF_FFFF);
      check("sub_ovf_c", bus.carry_out, 1);
      check("sub_ovf_f", bus.overflow, exp_ovf_flag);

      // start during RUN must be ignored
      acc0 = n_acc;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'h0000_0100; bus.b = 32'h0000_0023;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1111_1111;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      check("ignore_res", bus.result, 32'h0000_0123);
      check("ignore_acc", n_acc - acc0, 1);

      // reset mid-RUN aborts; release coincides with a new start
      done0 = n_done;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h0000_1234; bus.b = 32'h0000_0034;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_result", bus.result, 0);
      check("abort_carry", bus.carry_out, 0);
      bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h0000_0005; bus.b = 32'h0000_0003;
      @(negedge clk);
      check("abort_nodone", n_done - done0, 0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      check("post_rst_sub", bus.result, 32'h0000_0002);
      check("post_rst_c", bus.carry_out, 1);

      // random operands
      repeat (6) run_op(1'(($urandom_range(0, 1))), $urandom, $urandom);

      // back-to-back with start held high for 31 sampled edges
      acc0  = n_acc;
      done0 = n_done;
      @(negedge clk);
      bus.start = 1'b1;
      for (int i = 0; i < 31; i++) begin
         bus.op = 1'($urandom_range(0, 1));
         bus.a  = $urandom;
         bus.b  = $urandom;
         @(negedge clk);
      end
      bus.start = 1'b0;
      wait_idle();
      check("b2b_accepts", n_acc - acc0, 4);
      check("b2b_dones", n_done - done0, 4);
      check("sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
